// File: rtl/apb_ram_strb.sv
// apb_ram_strb: APB slave word-organised SRAM with byte-lane write strobes,
// a fixed number of access-phase wait states and out-of-range error response.
// Ports:
//   pclk, preset        clock, synchronous active-low reset
//   psel, penable       APB select / access-phase indicator
//   pwrite, paddr       direction and byte address (taken at setup edge)
//   pwdata, pstrb       write data and byte-lane enables (taken at completion)
//   prdata              read data, nonzero only on a good read completion
//   pready, pslverr     completion strobe and error, pslverr qualified by pready
module apb_ram_strb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 16384,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    addr_q, addr_d;
  logic             err_q, err_d;
  logic             wr_q, wr_d;
  logic [DATA_WIDTH-1:0] rd_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  err;
  logic                  setup;
  logic                  done;
  logic                  mem_we;

  assign idx   = paddr >> OFF_W;
  assign err   = {1'b0, idx} >= DEPTH_L;
  assign setup = (state_q == IDLE) && psel && !penable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    wr_d    = wr_q;
    pready  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = '0;
          addr_d  = idx[MW-1:0];
          err_d   = err;
          wr_d    = pwrite;
        end
      end
      ACCESS: begin
        // pready is withheld when psel drops so an aborted transfer never
        // looks like a completion on the bus.
        pready = psel && (cnt_q == CNT_MAX);
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (pready) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we = done && wr_q && !err_q;

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

  // Read data is captured straight from the array at the setup edge so the
  // array maps onto a synchronous-read block RAM with a resettable output
  // register; a combinational _d path would force an asynchronous read.
  always_ff @(posedge pclk) begin
    if (!preset) begin
      rd_q <= '0;
    end else if (setup && !err && !pwrite) begin
      rd_q <= mem[idx[MW-1:0]];
    end
  end

  // Array is not reset; a reset edge suppresses any write in flight.
  always_ff @(posedge pclk) begin
    if (preset && mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (pstrb[i]) mem[addr_q][8*i +: 8] <= pwdata[8*i +: 8];
      end
    end
  end

  assign prdata  = (pready && !wr_q && !err_q) ? rd_q : '0;
  assign pslverr = pready && err_q;

endmodule

// File: tb/tb_apb_ram_strb.sv
module tb_apb_ram_strb;

  localparam int NI = 3;
  localparam int WS_T    [NI] = '{0, 2, 3};
  localparam int DEPTH_T [NI] = '{1000, 16384, 64};

  logic                pclk = 1'b0;
  logic                preset;
  logic [NI-1:0]       psel;
  logic                penable;
  logic                pwrite;
  logic [15:0]         paddr;
  logic [31:0]         pwdata;
  logic [3:0]          pstrb;
  logic [NI-1:0][31:0] prdata;
  logic [NI-1:0]       pready;
  logic [NI-1:0]       pslverr;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_ram_strb #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16),
      .DEPTH(DEPTH_T[g]), .WAIT_STATES(WS_T[g])
    ) u_dut (
      .pclk(pclk), .preset(preset), .psel(psel[g]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata[g]), .pready(pready[g]), .pslverr(pslverr[g])
    );
  end

  typedef struct {
    int          k;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[int];   // key = instance*65536 + word index
  int          total = 0;
  int          passed = 0;
  int          acc[NI] = '{0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Monitor: counts access-phase cycles and checks every completion.
  always @(negedge pclk) begin
    for (int k = 0; k < NI; k++) begin
      if (!preset || !(psel[k] && penable)) acc[k] = 0;
      else begin
        acc[k]++;
        if (pready[k]) begin
          if (sb.size() == 0) chk("unexpected_pready", 32'(k), 32'hFFFF_FFFF);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("inst", 32'(k), 32'(e.k));
            chk("prdata", prdata[k], e.data);
            chk("pslverr", {31'b0, pslverr[k]}, {31'b0, e.err});
            chk("latency", 32'(acc[k]), 32'(e.lat));
          end
          acc[k] = 0;
        end
      end
    end
  end

  task automatic xfer(input int k, input bit wr, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   widx;
    int   key;
    bit   got;
    logic [31:0] w;
    widx  = int'(a) / 4;
    key   = k * 65536 + widx;
    e.k   = k;
    e.err = (widx >= DEPTH_T[k]);
    e.lat = WS_T[k] + 1;
    e.data = '0;
    if (wr) begin
      if (!e.err) begin
        w = mdl.exists(key) ? mdl[key] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[key] = w;
      end
    end else if (!e.err) begin
      e.data = mdl[key];
    end
    sb.push_back(e);
    @(posedge pclk); #1;
    psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    // Setup-time address changes must be ignored during ACCESS.
    paddr = 16'($urandom);
    pwrite = ~wr;
    #1 pwrite = wr;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge pclk);
      if (pready[k]) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(posedge pclk); #1;
    psel[k] = 1'b0; penable = 1'b0;
  endtask

  // Start a write, spend one access cycle, then abort by psel drop (mode 0)
  // or reset (mode 1); the word must stay as the model has it.
  task automatic abort_wr(input int k, input int mode, input logic [15:0] a);
    @(posedge pclk); #1;
    psel[k] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    if (mode == 0) begin psel[k] = 1'b0; penable = 1'b0; end
    else preset = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    chk("abort_pready", {31'b0, pready[k]}, 32'd0);
    chk("abort_pslverr", {31'b0, pslverr[k]}, 32'd0);
    chk("abort_prdata", prdata[k], 32'd0);
    @(posedge pclk); #1;
    preset = 1'b1; psel[k] = 1'b0; penable = 1'b0;
  endtask

  int pool[8] = '{0, 1, 5, 17, 33, 62, 999, 1000};

  initial begin
    preset = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge pclk);
      for (int k = 0; k < NI; k++) begin
        chk("rst_pready", {31'b0, pready[k]}, 32'd0);
        chk("rst_pslverr", {31'b0, pslverr[k]}, 32'd0);
        chk("rst_prdata", prdata[k], 32'd0);
      end
    end
    @(posedge pclk); #1 preset = 1'b1;

    // basic write/read, zero wait states
    xfer(0, 1, 16'h0010, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 0, 16'h0010, 32'h0, 4'h0);
    // strobed write merges lanes
    xfer(0, 1, 16'h0020, 32'h1122_3344, 4'hF);
    xfer(0, 1, 16'h0020, 32'hAABB_CCDD, 4'h5);
    xfer(0, 0, 16'h0022, 32'h0, 4'h0);
    // all-zero strobe is a no-op
    xfer(0, 1, 16'h0020, 32'h0000_0000, 4'h0);
    xfer(0, 0, 16'h0020, 32'h0, 4'h0);
    // wait states
    xfer(1, 1, 16'h0040, 32'hCAFE_F00D, 4'hF);
    xfer(1, 0, 16'h0040, 32'h0, 4'h0);
    // out of range around DEPTH = 1000
    xfer(0, 1, 16'd3996, 32'h0BAD_CAFE, 4'hF);
    xfer(0, 1, 16'd4000, 32'h1234_5678, 4'hF);
    xfer(0, 0, 16'd3996, 32'h0, 4'h0);
    xfer(0, 0, 16'd4000, 32'h0, 4'h0);
    // aborts with three wait states
    xfer(2, 1, 16'h0008, 32'h55AA_55AA, 4'hF);
    abort_wr(2, 0, 16'h0008);
    xfer(2, 0, 16'h0008, 32'h0, 4'h0);
    abort_wr(2, 1, 16'h0008);
    xfer(2, 0, 16'h0008, 32'h0, 4'h0);

    // randomized traffic over a pool of words, some out of range
    for (int k = 0; k < NI; k++)
      for (int p = 0; p < 8; p++)
        xfer(k, 1, 16'(pool[p] * 4), $urandom, 4'hF);
    for (int n = 0; n < 80; n++) begin
      int k;
      k = int'($urandom_range(0, NI - 1));
      xfer(k, 1'($urandom), 16'(pool[$urandom_range(0, 7)] * 4 + int'($urandom_range(0, 3))),
           $urandom, 4'($urandom));
    end

    repeat (3) @(posedge pclk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_ram_strb.md
# apb_ram_strb

Parametrised APB slave SRAM, the next generation of the team's fixed 16-bit APB RAM. Word-organised internal memory of configurable width and depth. Supports byte-lane write strobes, a programmable number of wait states, and error signalling on out-of-range addresses. It sits on the APB fabric behind the decoder's per-slave `psel` and replaces the fixed-width RAM in new subsystems.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8, 8..64
- ADDR_WIDTH, 16, paddr width in bits
- DEPTH, 16384, number of DATA_WIDTH-bit words; need not be a power of two
- WAIT_STATES, 0, access-phase cycles with pready low before completion; 0..15

Ports:
- pclk  in  1  APB clock; all logic on rising edge
- preset  in  1  reset; synchronous, active-low
- psel  in  1  slave select from decoder
- penable  in  1  APB access-phase indicator
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  byte-lane write enables; ignored on reads
- prdata  out  DATA_WIDTH  read data
- pready  out  1  transfer completes this cycle
- pslverr  out  1  transfer error; qualified by pready

## Operation
- Word index = paddr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
- Error condition err: word index >= DEPTH.
- FSM states:
  - IDLE: pready = 0. On psel && !penable (setup phase):
    - go to ACCESS
    - cnt <= 0
    - latch addr_q = word index, err_q = err, wr_q = pwrite
    - if !err && !pwrite: rd_q <= mem[index]
  - ACCESS: pready = (cnt == WAIT_STATES).
    - If psel && penable && pready: complete the transfer, go to IDLE.
    - If psel && penable && !pready: cnt <= cnt + 1.
    - If !psel (protocol violation): go to IDLE, no memory write, pready stays 0.
    - penable low while psel high: hold state and cnt.
- Write on completion edge, only if wr_q && !err_q: for each lane i with pstrb[i] = 1, mem[addr_q] byte i <= pwdata byte i. Lanes with strobe 0 are unchanged. Strobe all-zero is a legal no-op.
- Read return: prdata = rd_q when pready && !wr_q && !err_q, else 0.
- Error response: pslverr = pready && err_q. Erroneous writes are suppressed; erroneous reads return 0.
- Address and pwrite are taken from the setup edge; changes during ACCESS are ignored. pwdata and pstrb are sampled at the completion edge.
- Memory array: DEPTH x DATA_WIDTH, not reset, single port, inferable as block RAM with byte enables.

## Timing
- Reset (preset = 0 at a rising edge):
  - state = IDLE, cnt = 0, rd_q = 0, err_q = 0, wr_q = 0
  - outputs: pready = 0, pslverr = 0, prdata = 0
- Reset mid-transfer aborts it; no write occurs at the reset edge.
- Transfer length = 2 + WAIT_STATES cycles: one setup cycle plus 1 + WAIT_STATES access cycles. pready is asserted combinationally for exactly one cycle.
- Back-to-back transfers: the next setup phase may occur on the cycle immediately after completion (IDLE). Sustained throughput is one transfer per 2 + WAIT_STATES cycles.
- Read-after-write to the same word in consecutive transfers returns the new data: the write occurs at the completion edge, which precedes the next setup edge.
- cnt width = max(1, clog2(WAIT_STATES + 1)); never exceeds WAIT_STATES.

## Test plan
- Reset then idle: hold preset = 0 for 2 cycles with psel = 0 -> pready = 0, pslverr = 0, prdata = 0 on every cycle.
- Full write/read, WAIT_STATES = 0:
  - write paddr 0x0010, pwdata 0xDEADBEEF, pstrb 0xF -> pready high in cycle 2, pslverr = 0
  - read paddr 0x0010 -> prdata = 0xDEADBEEF with pready in cycle 2
- Strobed write: write 0x11223344 with pstrb 0xF, then 0xAABBCCDD with pstrb 0x5 to the same word -> readback 0x11BB33DD.
- Wait states, WAIT_STATES = 2: read transfer -> pready low for the first 2 access cycles, high on the 3rd. Total 4 cycles; data correct on pready.
- Out of range, DEPTH = 1000, DATA_WIDTH = 32:
  - write paddr 4000 (index 1000) -> pready with pslverr = 1
  - read index 999 -> data unchanged
  - read paddr 4000 -> prdata = 0, pslverr = 1
- Abort cases, WAIT_STATES = 3:
  - drop psel in ACCESS -> return to IDLE; the word is unmodified
  - assert preset = 0 in ACCESS -> outputs 0; a subsequent read shows no write occurred
